// File: rtl/serial_frame_rx.sv
// Bit-serial frame receiver: hunts a sync byte at bit granularity, then collects LEN
// payload bytes and checks a trailing check byte (XOR by default, CRC-8 with SFRX_CRC8_EN).
module serial_frame_rx #(
  parameter logic [7:0]  SYNC = 8'hA5,
  parameter int unsigned LEN  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bit_in,
  input  logic       bit_valid,
  input  logic       abort,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       frame_ok,
  output logic       frame_err,
  output logic       in_frame
);

  localparam logic [7:0] LEN_B = 8'(LEN);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2
  } state_t;

  state_t      state_q;
  logic [7:0]  sr_q;
  logic [2:0]  bitcnt_q;
  logic [7:0]  bytecnt_q;
  logic [7:0]  chk_q;
  logic [3:0]  hunt_cnt_q;
  logic [7:0]  byte_out_q;
  logic        byte_valid_q;
  logic        frame_ok_q;
  logic        frame_err_q;
  logic        in_frame_q;

  logic [7:0]  sr_d;
  logic [3:0]  hunt_cnt_d;
  logic [7:0]  bytecnt_d;
  logic [7:0]  chk_d;
  logic        lock;
  logic        byte_done;

  // One MSB-first step of CRC-8, polynomial x^8 + x^2 + x + 1.
  function automatic logic [7:0] crc8_bit(input logic [7:0] crc, input logic b);
    crc8_bit = {crc[6:0], 1'b0} ^ ((crc[7] ^ b) ? 8'h07 : 8'h00);
  endfunction

  always_comb begin
    sr_d       = {sr_q[6:0], bit_in};
    hunt_cnt_d = (hunt_cnt_q == 4'd8) ? 4'd8 : hunt_cnt_q + 4'd1;
    bytecnt_d  = bytecnt_q + 8'd1;
    lock       = (hunt_cnt_d == 4'd8) && (sr_d == SYNC);
    byte_done  = (bitcnt_q == 3'd7);
`ifdef SFRX_CRC8_EN
    chk_d      = crc8_bit(chk_q, bit_in);
`else
    chk_d      = chk_q ^ sr_d;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= HUNT;
      sr_q         <= 8'h00;
      bitcnt_q     <= 3'd0;
      bytecnt_q    <= 8'h00;
      chk_q        <= 8'h00;
      hunt_cnt_q   <= 4'd0;
      byte_out_q   <= 8'h00;
      byte_valid_q <= 1'b0;
      frame_ok_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      in_frame_q   <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      frame_ok_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      // Abort discards any coincident bit; byte_out deliberately keeps its value.
      if (abort) begin
        state_q    <= HUNT;
        bitcnt_q   <= 3'd0;
        bytecnt_q  <= 8'h00;
        chk_q      <= 8'h00;
        hunt_cnt_q <= 4'd0;
        in_frame_q <= 1'b0;
      end else if (bit_valid) begin
        sr_q <= sr_d;
        case (state_q)
          HUNT: begin
            hunt_cnt_q <= hunt_cnt_d;
            if (lock) begin
              state_q    <= PAYLOAD;
              bitcnt_q   <= 3'd0;
              bytecnt_q  <= 8'h00;
              chk_q      <= 8'h00;
              in_frame_q <= 1'b1;
            end
          end
          PAYLOAD: begin
            bitcnt_q <= bitcnt_q + 3'd1;
`ifdef SFRX_CRC8_EN
            chk_q <= chk_d;
`endif
            if (byte_done) begin
              byte_out_q   <= sr_d;
              byte_valid_q <= 1'b1;
              bytecnt_q    <= bytecnt_d;
`ifndef SFRX_CRC8_EN
              chk_q <= chk_d;
`endif
              if (bytecnt_d == LEN_B) begin
                state_q  <= CHECK;
                bitcnt_q <= 3'd0;
              end
            end
          end
          CHECK: begin
            bitcnt_q <= bitcnt_q + 3'd1;
            // hunt_cnt restarts at 0 so the check byte can never be taken as sync.
            if (byte_done) begin
              frame_ok_q  <= (sr_d == chk_q);
              frame_err_q <= (sr_d != chk_q);
              state_q     <= HUNT;
              hunt_cnt_q  <= 4'd0;
              bitcnt_q    <= 3'd0;
              bytecnt_q   <= 8'h00;
              chk_q       <= 8'h00;
              in_frame_q  <= 1'b0;
            end
          end
          default: state_q <= HUNT;
        endcase
      end
    end
  end

  assign byte_out   = byte_out_q;
  assign byte_valid = byte_valid_q;
  assign frame_ok   = frame_ok_q;
  assign frame_err  = frame_err_q;
  assign in_frame   = in_frame_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx (SYNC=A5, LEN=2); check bytes follow SFRX_CRC8_EN.
module tb_serial_frame_rx;

`ifdef SFRX_CRC8_EN
  localparam logic [7:0] GOOD = 8'h8B;
  localparam logic [7:0] BAD  = 8'hBD;
`else
  localparam logic [7:0] GOOD = 8'hBD;
  localparam logic [7:0] BAD  = 8'hBC;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       bit_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       frame_ok;
  logic       frame_err;
  logic       in_frame;

  serial_frame_rx #(.SYNC(8'hA5), .LEN(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .abort     (abort),
    .byte_out  (byte_out),
    .byte_valid(byte_valid),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .in_frame  (in_frame)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  int n_bv = 0, n_ok = 0, n_err = 0, n_if = 0, n_bad = 0;
  logic [7:0] got[$];
  int s_bv, s_ok, s_err, s_if, s_got;

  always @(negedge clk) begin
    if (rst_n) begin
      if (byte_valid) begin
        n_bv++;
        got.push_back(byte_out);
      end
      if (frame_ok)  n_ok++;
      if (frame_err) n_err++;
      if (in_frame)  n_if++;
      if ((frame_ok && frame_err) || (byte_valid && (frame_ok || frame_err))) n_bad++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic b, input logic v, input logic a);
    @(negedge clk);
    bit_in = b;
    bit_valid = v;
    abort = a;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    for (int i = 7; i >= 0; i--) begin
      for (int g = 0; g < gap; g++) cyc(1'b0, 1'b0, 1'b0);
      cyc(b[i], 1'b1, 1'b0);
    end
  endtask

  task automatic snap();
    s_bv = n_bv; s_ok = n_ok; s_err = n_err; s_if = n_if; s_got = got.size();
  endtask

  initial begin
    // Reset state
    #1 rst_n = 1'b0;
    idle(3);
    chk("rst_byte_out", 32'(byte_out), 32'h00);
    chk("rst_byte_valid", 32'(byte_valid), 32'h0);
    chk("rst_frame_ok", 32'(frame_ok), 32'h0);
    chk("rst_frame_err", 32'(frame_err), 32'h0);
    chk("rst_in_frame", 32'(in_frame), 32'h0);
    rst_n = 1'b1;
    idle(2);

    // Good frame, continuous strobe
    snap();
    send_byte(8'hA5, 0);
    chk("xor_lock_in_frame", 32'(in_frame), 32'h1);
    send_byte(8'h3C, 0);
    chk("xor_bv0", 32'(byte_valid), 32'h1);
    chk("xor_byte0", 32'(byte_out), 32'h3C);
    send_byte(8'h81, 0);
    chk("xor_byte1", 32'(byte_out), 32'h81);
    send_byte(GOOD, 0);
    chk("xor_frame_ok", 32'(frame_ok), 32'h1);
    chk("xor_frame_err", 32'(frame_err), 32'h0);
    chk("xor_in_frame_fall", 32'(in_frame), 32'h0);
    idle(1);
    chk("xor_ok_one_cycle", 32'(frame_ok), 32'h0);
    idle(2);
    chk("xor_in_frame_len", 32'(n_if - s_if), 32'd24);
    chk("xor_nbytes", 32'(n_bv - s_bv), 32'd2);
    chk("xor_got0", 32'(got[s_got]), 32'h3C);
    chk("xor_got1", 32'(got[s_got + 1]), 32'h81);

    // Bad check byte
    snap();
    send_byte(8'hA5, 0);
    send_byte(8'h3C, 0);
    send_byte(8'h81, 0);
    send_byte(BAD, 0);
    chk("bad_frame_err", 32'(frame_err), 32'h1);
    chk("bad_frame_ok", 32'(frame_ok), 32'h0);
    idle(2);
    chk("bad_nbytes", 32'(n_bv - s_bv), 32'd2);
    chk("bad_ok_count", 32'(n_ok - s_ok), 32'd0);
    chk("bad_hunt", 32'(in_frame), 32'h0);

    // Bit-aligned hunt: four leading ones
    snap();
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0);
    for (int i = 7; i >= 1; i--) cyc(8'hA5 >> i & 8'h01 ? 1'b1 : 1'b0, 1'b1, 1'b0);
    chk("hunt_no_lock_11", 32'(in_frame), 32'h0);
    cyc(1'b1, 1'b1, 1'b0);
    chk("hunt_lock_12", 32'(in_frame), 32'h1);
    send_byte(8'h3C, 0);
    send_byte(8'h81, 0);
    send_byte(GOOD, 0);
    chk("hunt_frame_ok", 32'(frame_ok), 32'h1);
    idle(2);
    chk("hunt_nbytes", 32'(n_bv - s_bv), 32'd2);
    chk("hunt_got1", 32'(got[s_got + 1]), 32'h81);

    // Gapped strobe
    snap();
    send_byte(8'hA5, 1);
    send_byte(8'h3C, 1);
    send_byte(8'h81, 1);
    send_byte(GOOD, 1);
    chk("gap_frame_ok", 32'(frame_ok), 32'h1);
    idle(2);
    chk("gap_in_frame_len", 32'(n_if - s_if), 32'd48);
    chk("gap_got0", 32'(got[s_got]), 32'h3C);
    chk("gap_got1", 32'(got[s_got + 1]), 32'h81);

    // Gapped strobe with abort after the 20th bit
    snap();
    send_byte(8'hA5, 1);
    send_byte(8'h3C, 1);
    for (int i = 7; i >= 4; i--) begin
      cyc(1'b0, 1'b0, 1'b0);
      cyc((8'h81 >> i) & 8'h01 ? 1'b1 : 1'b0, 1'b1, 1'b0);
    end
    chk("abort_pre_in_frame", 32'(in_frame), 32'h1);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1);
    chk("abort_in_frame", 32'(in_frame), 32'h0);
    chk("abort_byte_hold", 32'(byte_out), 32'h3C);
    idle(10);
    chk("abort_no_ok", 32'(n_ok - s_ok), 32'd0);
    chk("abort_no_err", 32'(n_err - s_err), 32'd0);
    chk("abort_nbytes", 32'(n_bv - s_bv), 32'd1);
    snap();
    send_byte(8'hA5, 0);
    send_byte(8'h3C, 0);
    send_byte(8'h81, 0);
    send_byte(GOOD, 0);
    chk("post_abort_ok", 32'(frame_ok), 32'h1);
    idle(2);
    chk("post_abort_nbytes", 32'(n_bv - s_bv), 32'd2);

    // Reset mid-frame
    send_byte(8'hA5, 0);
    send_byte(8'h3C, 0);
    chk("mid_bv", 32'(byte_valid), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_byte_out", 32'(byte_out), 32'h00);
    chk("mid_rst_byte_valid", 32'(byte_valid), 32'h0);
    chk("mid_rst_in_frame", 32'(in_frame), 32'h0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    snap();
    send_byte(8'h81, 0);
    send_byte(GOOD, 0);
    idle(2);
    chk("mid_tail_no_bytes", 32'(n_bv - s_bv), 32'd0);
    chk("mid_tail_no_ok", 32'(n_ok - s_ok), 32'd0);
    chk("mid_tail_no_err", 32'(n_err - s_err), 32'd0);
    snap();
    send_byte(8'hA5, 0);
    send_byte(8'h3C, 0);
    send_byte(8'h81, 0);
    send_byte(GOOD, 0);
    chk("mid_full_ok", 32'(frame_ok), 32'h1);
    idle(2);
    chk("mid_full_nbytes", 32'(n_bv - s_bv), 32'd2);

    chk("no_pulse_overlap", 32'(n_bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
